// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers plus a fixed-latency busy
// window that stalls the front end while a mult/div result is pending.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [1:0]  op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        wr_hi_E,
  input  logic        wr_lo_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        state_o
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor, quot_s, rem_s, quot_u, rem_u;

  // Divisor is forced non-zero so simulation never sees X; the zero case
  // never commits anyway.
  always_comb begin
    divisor = (b_q == 32'd0) ? 32'd1 : b_q;
    prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    quot_s  = $signed(a_q) / $signed(divisor);
    rem_s   = $signed(a_q) % $signed(divisor);
    quot_u  = a_q / divisor;
    rem_u   = a_q % divisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_E) begin
          a_d     = rs_E;
          b_d     = rt_E;
          op_d    = op_E;
          cnt_d   = op_E[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          state_d = BUSY;
        end else begin
          if (wr_hi_E) hi_d = rs_E;
          if (wr_lo_E) lo_d = rs_E;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          case (op_q)
            2'b00: begin hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
            2'b01: begin hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
            2'b10: if (b_q != 32'd0) begin hi_d = rem_s; lo_d = quot_s; end
            default: if (b_q != 32'd0) begin hi_d = rem_u; lo_d = quot_u; end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall is built only from inputs and busy state, never from itself.
  assign busy    = (state_q == BUSY);
  assign stall   = md_use_D & (start_E | busy);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: reset, mult/div results and latency, hazard
// stall, mthi/mtlo boundaries, busy-time input masking and mid-op reset.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start_E;
  logic [1:0]  op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        wr_hi_E;
  logic        wr_lo_E;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        state_o;

  int vec_cnt;
  int err_cnt;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_E  (start_E),
    .op_E     (op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .wr_hi_E  (wr_hi_E),
    .wr_lo_E  (wr_lo_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .state_o  (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: every task starts and ends 1 time unit after a posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_E = 1'b1;
    op_E    = op;
    rs_E    = a;
    rt_E    = b;
    tick();
    start_E = 1'b0;
    rs_E    = '0;
    rt_E    = '0;
  endtask

  task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] v);
    wr_hi_E = wh;
    wr_lo_E = wl;
    rs_E    = v;
    tick();
    wr_hi_E = 1'b0;
    wr_lo_E = 1'b0;
    rs_E    = '0;
  endtask

  // Counts busy cycles (bounded) and notes whether hi/lo moved while busy.
  task automatic wait_idle(input logic [31:0] h0, input logic [31:0] l0,
                           output int cycles, output bit changed);
    cycles  = 0;
    changed = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      if (hi !== h0 || lo !== l0) changed = 1'b1;
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_E = 1'b1; wr_hi_E = 1'b1; wr_lo_E = 1'b1; rs_E = 32'h5555_AAAA;
    tick();
    tick();
    reset = 1'b0; start_E = 1'b0; wr_hi_E = 1'b0; wr_lo_E = 1'b0; rs_E = '0;
    vec_cnt++;
    if (busy !== 1'b0 || state_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_busy: busy=%b state=%b required 0/0", busy, state_o);
    end
    vec_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      err_cnt++; $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
    end
    md_use_D = 1'b1;
    #1;
    vec_cnt++;
    if (stall !== 1'b0) begin
      err_cnt++; $display("FAIL reset_stall_idle: stall=%b required 0", stall);
    end
    start_E = 1'b1;
    #1;
    vec_cnt++;
    if (stall !== 1'b1) begin
      err_cnt++; $display("FAIL reset_stall_start: stall=%b required 1", stall);
    end
    start_E = 1'b0;
    md_use_D = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int n; bit ch;
    issue_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    wait_idle(32'd0, 32'd0, n, ch);
    vec_cnt++;
    if (n !== 5 || ch !== 1'b0) begin
      err_cnt++; $display("FAIL mult_latency: busy=%0d changed=%0b required 5/0", n, ch);
    end
    vec_cnt++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      err_cnt++; $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffa", hi, lo);
    end
  endtask

  task automatic test_multu();
    int n; bit ch;
    issue_op(2'b01, 32'hFFFF_FFFE, 32'd3);
    wait_idle(32'hFFFF_FFFF, 32'hFFFF_FFFA, n, ch);
    vec_cnt++;
    if (n !== 5 || ch !== 1'b0) begin
      err_cnt++; $display("FAIL multu_latency: busy=%0d changed=%0b required 5/0", n, ch);
    end
    vec_cnt++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      err_cnt++; $display("FAIL multu_result: hi=%h lo=%h required 00000002/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int n; bit ch;
    issue_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle(32'h0000_0002, 32'hFFFF_FFFA, n, ch);
    vec_cnt++;
    if (n !== 10 || ch !== 1'b0) begin
      err_cnt++; $display("FAIL div_latency: busy=%0d changed=%0b required 10/0", n, ch);
    end
    vec_cnt++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      err_cnt++; $display("FAIL div_neg_dividend: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
    end
    // 7 / -2 -> q=-3, r=+1 (remainder follows dividend)
    issue_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_idle(32'hFFFF_FFFF, 32'hFFFF_FFFD, n, ch);
    vec_cnt++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
      err_cnt++; $display("FAIL div_neg_divisor: hi=%h lo=%h required 00000001/fffffffd", hi, lo);
    end
    issue_op(2'b11, 32'd100, 32'd7);
    wait_idle(32'd1, 32'hFFFF_FFFD, n, ch);
    vec_cnt++;
    if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
      err_cnt++; $display("FAIL divu_result: busy=%0d hi=%h lo=%h required 10/00000002/0000000e", n, hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int n; bit ch;
    issue_op(2'b11, 32'h1234_5678, 32'd0);
    wait_idle(32'd2, 32'd14, n, ch);
    vec_cnt++;
    if (n !== 10 || ch !== 1'b0) begin
      err_cnt++; $display("FAIL divu_zero_latency: busy=%0d changed=%0b required 10/0", n, ch);
    end
    vec_cnt++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      err_cnt++; $display("FAIL divu_zero_hold: hi=%h lo=%h required 00000002/0000000e", hi, lo);
    end
  endtask

  task automatic test_hazard();
    int bad;
    bad = 0;
    md_use_D = 1'b1;
    start_E = 1'b1; op_E = 2'b00; rs_E = 32'd5; rt_E = 32'd6;
    #1;
    vec_cnt++;
    if (stall !== 1'b1) begin
      err_cnt++; $display("FAIL hazard_start_stall: stall=%b required 1", stall);
    end
    tick();
    start_E = 1'b0; rs_E = '0; rt_E = '0;
    for (int i = 0; i < 5; i++) begin
      if (stall !== 1'b1 || busy !== 1'b1) bad++;
      tick();
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++; $display("FAIL hazard_busy_stall: %0d cycles without stall/busy, required 0", bad);
    end
    vec_cnt++;
    if (stall !== 1'b0 || busy !== 1'b0 || lo !== 32'd30 || hi !== 32'd0) begin
      err_cnt++; $display("FAIL hazard_release: stall=%b busy=%b hi=%h lo=%h required 0/0/00000000/0000001e",
                          stall, busy, hi, lo);
    end
    md_use_D = 1'b0;
  endtask

  task automatic test_hilo_write();
    int n; bit ch;
    write_hilo(1'b1, 1'b0, 32'h0000_1234);
    vec_cnt++;
    if (hi !== 32'h0000_1234 || lo !== 32'd30) begin
      err_cnt++; $display("FAIL mthi: hi=%h lo=%h required 00001234/0000001e", hi, lo);
    end
    write_hilo(1'b1, 1'b1, 32'h0000_ABCD);
    vec_cnt++;
    if (hi !== 32'h0000_ABCD || lo !== 32'h0000_ABCD) begin
      err_cnt++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h required 0000abcd/0000abcd", hi, lo);
    end
    // start_E wins over a same-cycle mtlo
    wr_lo_E = 1'b1;
    issue_op(2'b01, 32'd7, 32'd9);
    wr_lo_E = 1'b0;
    vec_cnt++;
    if (lo !== 32'h0000_ABCD || busy !== 1'b1) begin
      err_cnt++; $display("FAIL start_vs_mtlo_drop: lo=%h busy=%b required 0000abcd/1", lo, busy);
    end
    wait_idle(32'h0000_ABCD, 32'h0000_ABCD, n, ch);
    vec_cnt++;
    if (hi !== 32'd0 || lo !== 32'd63) begin
      err_cnt++; $display("FAIL start_vs_mtlo_result: hi=%h lo=%h required 00000000/0000003f", hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    int n; bit ch;
    issue_op(2'b01, 32'd3, 32'd4);
    start_E = 1'b1; op_E = 2'b10; wr_hi_E = 1'b1; wr_lo_E = 1'b1; rs_E = 32'hDEAD_BEEF; rt_E = 32'd1;
    tick();
    start_E = 1'b0; wr_hi_E = 1'b0; wr_lo_E = 1'b0; rs_E = '0; rt_E = '0;
    wait_idle(32'd0, 32'd63, n, ch);
    vec_cnt++;
    if (n !== 4 || ch !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
      err_cnt++; $display("FAIL busy_ignore: rest=%0d changed=%0b hi=%h lo=%h required 4/0/00000000/0000000c",
                          n, ch, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int late;
    late = 0;
    write_hilo(1'b1, 1'b1, 32'h0000_0011);
    issue_op(2'b10, 32'd100, 32'd3);
    tick();
    tick();
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++; $display("FAIL reset_mid_pre: busy=%b required 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      err_cnt++; $display("FAIL reset_mid_abort: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late++;
      tick();
    end
    vec_cnt++;
    if (late !== 0) begin
      err_cnt++; $display("FAIL reset_mid_no_commit: %0d bad cycles, required 0", late);
    end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    reset = 1'b1; start_E = 1'b0; op_E = '0; rs_E = '0; rt_E = '0;
    wr_hi_E = 1'b0; wr_lo_E = 1'b0; md_use_D = 1'b0;
    #1;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_hazard();
    test_hilo_write();
    test_busy_ignore();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
